// File: rtl/ref_timer.sv
// Refresh request timer: a free-running prescaler issues refresh ticks that
// accumulate as pending credit, and each acknowledgement pulse retires one.
module ref_timer #(
  parameter int INTERVAL  = 235,
  parameter int URGENT_AT = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic RefAck,
  output logic RefReq,
  output logic RefUrgent,
  output logic RefLost
);

  localparam logic [7:0] CntLast   = 8'(INTERVAL - 1);
  localparam logic [1:0] UrgentLvl = 2'(URGENT_AT);
  localparam logic [1:0] PendMax   = 2'd3;

  logic [7:0] cntR;
  logic [1:0] pendR;
  logic       ackQR;
  logic       refReqR;
  logic       refUrgentR;
  logic       refLostR;

  logic       tickS;
  logic       ackEdgeS;
  logic [1:0] pendNextS;
  logic       lostSetS;

  // Tick, acknowledge edge detection and next pending count
  always_comb begin
    tickS     = (cntR == CntLast);
    ackEdgeS  = RefAck & ~ackQR;
    pendNextS = pendR;
    lostSetS  = 1'b0;
    case ({tickS, ackEdgeS})
      2'b10: begin
        if (pendR != PendMax) begin
          pendNextS = pendR + 2'd1;
        end else begin
          lostSetS = 1'b1;
        end
      end
      2'b01: begin
        if (pendR != 2'd0) begin
          pendNextS = pendR - 2'd1;
        end else begin
          pendNextS = pendR;
        end
      end
      // A tick and an ack on the same edge cancel, even at the limits
      default: pendNextS = pendR;
    endcase
  end

  // State and registered outputs; the ack history follows RefAck through
  // reset so an ack held high across release is not seen as a new edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      cntR       <= 8'd0;
      pendR      <= 2'd0;
      ackQR      <= RefAck;
      refReqR    <= 1'b0;
      refUrgentR <= 1'b0;
      refLostR   <= 1'b0;
    end else begin
      cntR       <= tickS ? 8'd0 : cntR + 8'd1;
      pendR      <= pendNextS;
      ackQR      <= RefAck;
      refReqR    <= (pendNextS != 2'd0);
      refUrgentR <= (pendNextS >= UrgentLvl);
      refLostR   <= refLostR | lostSetS;
    end
  end

  assign RefReq    = refReqR;
  assign RefUrgent = refUrgentR;
  assign RefLost   = refLostR;

endmodule

// File: tb/tb_ref_timer.sv
// Directed bench for ref_timer (INTERVAL=8, URGENT_AT=2) with a behavioural
// model feeding an expected-output queue that is checked after every edge.
module tb_ref_timer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RefAck = 1'b0;
  logic RefReq, RefUrgent, RefLost;

  int nAssert = 0;
  int nFail   = 0;

  logic [2:0] mCnt  = 3'd0;
  logic [1:0] mPend = 2'd0;
  logic       mAckQ = 1'b0;
  logic       mLost = 1'b0;
  logic [2:0] expQ[$];

  ref_timer #(.INTERVAL(8), .URGENT_AT(2)) dut (
    .CLK(CLK), .RST(RST), .RefAck(RefAck),
    .RefReq(RefReq), .RefUrgent(RefUrgent), .RefLost(RefLost)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic ack, input logic rst);
    logic       tick, ackEdge;
    logic [2:0] want;
    @(negedge CLK);
    RefAck = ack;
    RST    = rst;
    if (rst) begin
      mCnt = 3'd0; mPend = 2'd0; mAckQ = ack; mLost = 1'b0;
    end else begin
      tick    = (mCnt == 3'd7);
      ackEdge = ack && !mAckQ;
      mAckQ   = ack;
      mCnt    = mCnt + 3'd1;
      if (tick && !ackEdge) begin
        if (mPend == 2'd3) mLost = 1'b1;
        else mPend = mPend + 2'd1;
      end else if (ackEdge && !tick && mPend != 2'd0) begin
        mPend = mPend - 2'd1;
      end
    end
    expQ.push_back({mPend != 2'd0, mPend >= 2'd2, mLost});
    @(posedge CLK);
    #1;
    want = expQ.pop_front();
    nAssert++;
    assert ({RefReq, RefUrgent, RefLost} === want)
    else begin
      nFail++;
      $error("FAIL cycle: observed req/urg/lost %b expected %b",
             {RefReq, RefUrgent, RefLost}, want);
    end
  endtask

  initial begin
    int n;
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_req", RefReq, 1'b0);
    check("rst_urg", RefUrgent, 1'b0);
    check("rst_lost", RefLost, 1'b0);

    // First tick on the 8th edge, urgent on the 16th
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    check("pre_tick_req", RefReq, 1'b0);
    step(1'b0, 1'b0);
    check("tick1_req", RefReq, 1'b1);
    check("tick1_urg", RefUrgent, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    check("tick2_urg", RefUrgent, 1'b1);

    // Saturate at 3, then lose a tick; lost stays through acks
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0);
    check("lost_set", RefLost, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    check("drained_req", RefReq, 1'b0);
    check("lost_sticky", RefLost, 1'b1);
    step(1'b0, 1'b1);
    check("lost_clr", RefLost, 1'b0);

    // Spurious ack at zero gives no negative credit
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("no_neg_credit", RefReq, 1'b1);

    // Long ack counts once
    step(1'b1, 1'b0);
    check("long_ack_first", RefReq, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    check("long_ack_rest", RefReq, 1'b0);
    step(1'b0, 1'b0);

    // Reach 3, then ack rising on the tick edge
    n = 0;
    while (mPend != 2'd3 && n < 100) begin step(1'b0, 1'b0); n++; end
    check("reach3_bound", n < 100, 1'b1);
    n = 0;
    while (mCnt != 3'd7 && n < 20) begin step(1'b0, 1'b0); n++; end
    check("align_bound", n < 20, 1'b1);
    check("pre_coinc_lost", RefLost, 1'b0);
    step(1'b1, 1'b0);
    check("coinc_urg", RefUrgent, 1'b1);
    check("coinc_lost", RefLost, 1'b0);
    step(1'b0, 1'b0);

    // Pend=2 with ack held high through a one-cycle reset
    step(1'b1, 1'b0);
    check("pend2_urg", RefUrgent, 1'b1);
    step(1'b1, 1'b1);
    check("rst_mid_req", RefReq, 1'b0);
    check("rst_mid_urg", RefUrgent, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    check("held_ack_pre", RefReq, 1'b0);
    step(1'b1, 1'b0);
    check("held_ack_tick", RefReq, 1'b1);
    step(1'b1, 1'b0);
    check("held_ack_ignored", RefReq, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("new_ack_counts", RefReq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
